// File: rtl/channel_frame_mux.sv
`timescale 1ns/1ps
// channel_frame_mux: N-channel sample selector for the BRAM capture path.
// Channel changes are deferred to frame boundaries so a captured frame never
// mixes channels; the first SETTLE samples after every switch are blanked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | one cycle after reset: latch the requested channel
// ST_SETTLE | drop samples of the new channel while ADC/filter settles
// ST_RUN    | forward samples, frame counting, switch only at o_last
module channel_frame_mux #(
    parameter int NUM_CH    = 4,
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int SETTLE    = 8,
    localparam int CW       = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          i_channel_sel,
    input  logic [NUM_CH*DW-1:0] i_data,
    input  logic [NUM_CH-1:0]    i_valid,
    output logic [DW-1:0]        o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic [CW-1:0]        o_cur_ch,
    output logic                 o_sel_err
);

    localparam int SCW = $clog2(FRAME_LEN + 1);
    localparam int STW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SCW-1:0] FRAME_LAST  = SCW'(FRAME_LEN - 1);
    localparam logic [STW-1:0] SETTLE_LAST = (SETTLE > 0) ? STW'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [SCW-1:0]  sample_cnt, sample_cnt_nx;
    logic [STW-1:0]  settle_cnt, settle_cnt_nx;
    logic [CW-1:0]   cur_ch_nx;
    logic [DW-1:0]   data_nx;
    logic            valid_nx;
    logic            last_nx;

    logic            sel_in_range;
    logic [CW-1:0]   target;
    logic            sample_valid;
    logic [DW-1:0]   sample_data;

    // Full 32-bit range check; out-of-range requests fall back to channel 0.
    always_comb begin
        sel_in_range = (i_channel_sel < 32'(NUM_CH));
        target       = sel_in_range ? i_channel_sel[CW-1:0] : '0;
    end

    // Pick the strobe and sample of the currently routed channel only.
    always_comb begin
        sample_valid = 1'b0;
        sample_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (o_cur_ch == CW'(k)) begin
                sample_valid = i_valid[k];
                sample_data  = i_data[k*DW +: DW];
            end
        end
    end

    // Next-state and output decode; o_valid/o_last default to a single-cycle strobe.
    always_comb begin
        state_nx      = state;
        cur_ch_nx     = o_cur_ch;
        sample_cnt_nx = sample_cnt;
        settle_cnt_nx = settle_cnt;
        data_nx       = o_data;
        valid_nx      = 1'b0;
        last_nx       = 1'b0;
        case (state)
            ST_LOAD: begin
                cur_ch_nx     = target;
                settle_cnt_nx = '0;
                sample_cnt_nx = '0;
                state_nx      = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (sample_valid) begin
                    settle_cnt_nx = settle_cnt + STW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    valid_nx = 1'b1;
                    data_nx  = sample_data;
                    if (sample_cnt == FRAME_LAST) begin
                        last_nx       = 1'b1;
                        sample_cnt_nx = '0;
                        // target is only looked at here, so mid-frame changes are lost
                        if (target != o_cur_ch) begin
                            cur_ch_nx     = target;
                            settle_cnt_nx = '0;
                            state_nx      = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                        end
                    end else begin
                        sample_cnt_nx = sample_cnt + SCW'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_LOAD;
            end
        endcase
    end

    // State, counters and registered outputs; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            sample_cnt <= '0;
            settle_cnt <= '0;
            o_cur_ch   <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_sel_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            sample_cnt <= sample_cnt_nx;
            settle_cnt <= settle_cnt_nx;
            o_cur_ch   <= cur_ch_nx;
            o_data     <= data_nx;
            o_valid    <= valid_nx;
            o_last     <= last_nx;
            o_sel_err  <= ~sel_in_range;
        end
    end

endmodule

// File: tb/tb_channel_frame_mux.sv
`timescale 1ns/1ps
// Bench for channel_frame_mux: directed scenarios plus a randomized run,
// all checked against a sample-level behavioural model.
module tb_channel_frame_mux;

    localparam int NUM_CH    = 4;
    localparam int DW        = 16;
    localparam int FRAME_LEN = 8;
    localparam int SETTLE    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [31:0]          sel;
    logic [NUM_CH*DW-1:0] dat_bus;
    logic [NUM_CH-1:0]    vld;
    logic [DW-1:0]        o_data;
    logic                 o_valid;
    logic                 o_last;
    logic [1:0]           o_cur_ch;
    logic                 o_sel_err;

    int total = 0;
    int bad   = 0;
    logic [11:0] cnt = '0;

    // model state: pending channel latch, samples still to blank, position in frame
    bit          m_load;
    int          m_blank;
    int          m_pos;
    int          m_cur;
    bit          m_valid;
    bit          m_last;
    bit          m_err;
    logic [DW-1:0] m_data;

    channel_frame_mux #(
        .NUM_CH   (NUM_CH),
        .DW       (DW),
        .FRAME_LEN(FRAME_LEN),
        .SETTLE   (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_channel_sel(sel),
        .i_data       (dat_bus),
        .i_valid      (vld),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .o_cur_ch     (o_cur_ch),
        .o_sel_err    (o_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh_data();
        for (int k = 0; k < NUM_CH; k++) begin
            dat_bus[k*DW +: DW] = {4'(k), cnt};
        end
    endtask

    task automatic model_reset();
        m_load  = 1'b1;
        m_blank = 0;
        m_pos   = 0;
        m_cur   = 0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
    endtask

    // One clock of the reference: what the outputs must show after this edge.
    task automatic model_step();
        int tgt;
        tgt     = (sel < 32'(NUM_CH)) ? int'(sel) : 0;
        m_err   = (sel >= 32'(NUM_CH));
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (m_load) begin
            m_cur   = tgt;
            m_blank = SETTLE;
            m_pos   = 0;
            m_load  = 1'b0;
        end else if (vld[m_cur]) begin
            if (m_blank > 0) begin
                m_blank = m_blank - 1;
            end else begin
                m_valid = 1'b1;
                m_data  = dat_bus[m_cur*DW +: DW];
                m_pos   = m_pos + 1;
                if (m_pos == FRAME_LEN) begin
                    m_last = 1'b1;
                    m_pos  = 0;
                    if (tgt != m_cur) begin
                        m_cur   = tgt;
                        m_blank = SETTLE;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        cnt = cnt + 12'd1;
        refresh_data();
    endtask

    task automatic do_reset(input logic [31:0] s);
        sel   = s;
        vld   = 4'hf;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel   = 32'd1;
        vld   = 4'hf;
        rst_n = 1'b0;
        refresh_data();
        model_reset();
        tick();
        tick();
        total++;
        if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", {o_valid, o_last, o_cur_ch, o_sel_err, o_data});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        int nfwd = 0, nlast = 0, first = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL startup_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
            if (o_valid) nfwd++;
            if (o_last) nlast++;
            if (o_valid && first == 0) first = i;
        end
        total++;
        if (first != 4 || nfwd != 16 || nlast != 2 || o_cur_ch !== 2'd1) begin
            bad++;
            $display("FAIL startup_counts: got first=%0d fwd=%0d last=%0d ch=%0d expected 4 16 2 1",
                     first, nfwd, nlast, o_cur_ch);
        end
    endtask

    task automatic test_switch();
        int n1 = 0, f3 = 0;
        for (int i = 1; i <= 3; i++) tick();
        sel = 32'd3;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL switch_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
            if (o_valid && o_data[15:12] == 4'h1) n1++;
            if (o_valid && o_data[15:12] == 4'h3 && f3 == 0) f3 = i;
        end
        total++;
        if (n1 != 5 || f3 != 8 || o_cur_ch !== 2'd3) begin
            bad++;
            $display("FAIL switch_counts: got ch1=%0d first_ch3=%0d ch=%0d expected 5 8 3", n1, f3, o_cur_ch);
        end
    endtask

    task automatic test_sel_err();
        sel = 32'd7;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL selerr_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
            if (i == 1) begin
                total++;
                if (o_sel_err !== 1'b1) begin
                    bad++;
                    $display("FAIL selerr_flag: got %b expected 1", o_sel_err);
                end
            end
        end
        total++;
        if (o_cur_ch !== 2'd0) begin
            bad++;
            $display("FAIL selerr_fallback_ch: got %0d expected 0", o_cur_ch);
        end
        sel = 32'd2;
        tick();
        total++;
        if (o_sel_err !== 1'b0) begin
            bad++;
            $display("FAIL selerr_clear: got %b expected 0", o_sel_err);
        end
    endtask

    task automatic test_toggle();
        int gaps = 0, offch = 0;
        do_reset(32'd1);
        for (int i = 1; i <= 6; i++) tick();
        for (int i = 1; i <= 14; i++) begin
            sel = (i <= 2) ? 32'd2 : 32'd1;
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL toggle_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
            if (!o_valid) gaps++;
            if (o_cur_ch !== 2'd1) offch++;
        end
        total++;
        if (gaps != 0 || offch != 0) begin
            bad++;
            $display("FAIL toggle_noswitch: got gaps=%0d offch=%0d expected 0 0", gaps, offch);
        end
    endtask

    task automatic test_reset_midframe();
        int first = 0, nlast = 0;
        do_reset(32'd1);
        for (int i = 1; i <= 8; i++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== 21'd0) begin
            bad++;
            $display("FAIL midreset_async: got %h expected 0", {o_valid, o_last, o_cur_ch, o_sel_err, o_data});
        end
        model_reset();
        for (int i = 1; i <= 2; i++) begin
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== 21'd0) begin
                bad++;
                $display("FAIL midreset_hold%0d: got %h expected 0", i, {o_valid, o_last, o_cur_ch, o_sel_err, o_data});
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (o_valid && first == 0) first = i;
            if (o_last) nlast++;
        end
        total++;
        if (first != 4 || nlast != 1) begin
            bad++;
            $display("FAIL midreset_restart: got first=%0d last=%0d expected 4 1", first, nlast);
        end
    endtask

    task automatic test_sparse();
        int offch = 0, nlast = 0;
        do_reset(32'd1);
        for (int i = 1; i <= 40; i++) begin
            vld = 4'b1101 | ((cnt % 12'd3 == 12'd0) ? 4'b0010 : 4'b0000);
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL sparse_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
            if (o_valid && o_data[15:12] != 4'h1) offch++;
            if (o_last) nlast++;
        end
        total++;
        if (offch != 0 || nlast < 1) begin
            bad++;
            $display("FAIL sparse_only_ch1: got offch=%0d last=%0d expected 0 >=1", offch, nlast);
        end
    endtask

    task automatic test_random();
        int pick;
        do_reset(32'd0);
        for (int i = 1; i <= 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pick = int'($urandom_range(0, 6));
                sel  = (pick == 6) ? 32'h8000_0001 : 32'(pick);
            end
            vld = 4'($urandom);
            tick();
            total++;
            if ({o_valid, o_last, o_cur_ch, o_sel_err, o_data} !== {m_valid, m_last, 2'(m_cur), m_err, m_data}) begin
                bad++;
                $display("FAIL random_c%0d: got %h expected %h", i,
                         {o_valid, o_last, o_cur_ch, o_sel_err, o_data}, {m_valid, m_last, 2'(m_cur), m_err, m_data});
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_switch();
        test_sel_err();
        test_toggle();
        test_reset_midframe();
        test_sparse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
